// File: rtl/tla_pkg.sv
// Shared constants for the Ga-domain open/close responder: status codes,
// FSM encoding and default widths.
package tla_pkg;

    localparam int unsigned LDD0_0_DEF   = 32;
    localparam int unsigned TOP0_0_DEF   = 3;
    localparam int unsigned DONE_STR_DEF = 4;

    // Status codes returned to the Gc side on Ga_wdis
    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_RUN    = 3'b001;
    localparam logic [2:0] ST_STOP   = 3'b010;
    localparam logic [2:0] ST_CLOSED = 3'b011;
    localparam logic [2:0] ST_ERR    = 3'b100;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_STOP = 2'b10;

endpackage

// File: rtl/tla_pulse_stretch.sv
// Down-counter pulse stretcher: a one-cycle trigger becomes a registered
// LEN-cycle pulse; a retrigger while active reloads the count.
module tla_pulse_stretch
    import tla_pkg::*;
#(
    parameter int unsigned LEN = DONE_STR_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic pulse
);

    localparam int unsigned CW = $clog2(LEN + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= trig || (cnt > CW'(1));
            if (trig) begin
                cnt <= CW'(LEN);
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/tla_ga_com_resp.sv
// Ga_clk200 responder: runs a periodic gate train between open and close
// commands and returns a held status code plus a stretched done pulse.
module tla_ga_com_resp
    import tla_pkg::*;
#(
    parameter int unsigned LDD0_0   = LDD0_0_DEF,
    parameter int unsigned TOP0_0   = TOP0_0_DEF,
    parameter int unsigned DONE_STR = DONE_STR_DEF
) (
    input  logic              Ga_clk200,
    input  logic              Ga_rst,
    input  logic              Ga_com_open,
    input  logic              Ga_com_close,
    input  logic [TOP0_0-1:0] Ga_com_wdis,
    input  logic [LDD0_0-1:0] Ga_com_plus,
    output logic              Ga_gate,
    output logic              Ga_busy,
    output logic [15:0]       Ga_period_cnt,
    output logic [TOP0_0-1:0] Ga_wdis,
    output logic              Ga_done
);

    logic [1:0]        state, state_nxt;
    logic [LDD0_0-1:0] p_reg, p_nxt;
    logic [LDD0_0-1:0] weff_reg, weff_nxt;
    logic [LDD0_0-1:0] phase, phase_nxt;
    logic              gate_nxt, busy_nxt;
    logic [15:0]       cnt_nxt;
    logic [TOP0_0-1:0] wdis_nxt;
    logic              done_trig_c;

    logic [LDD0_0-1:0] w_c, plus_m1_c, weff_c, phase_inc_c;
    logic [15:0]       cnt_inc_c;
    logic              last_c, gate_on_c;

    // Effective width is capped at P-1 so every period has at least one low cycle
    assign w_c         = LDD0_0'(1) << Ga_com_wdis;
    assign plus_m1_c   = Ga_com_plus - LDD0_0'(1);
    assign weff_c      = (w_c < plus_m1_c) ? w_c : plus_m1_c;
    assign last_c      = (phase == p_reg - LDD0_0'(1));
    assign gate_on_c   = (p_reg == LDD0_0'(1)) || (phase < weff_reg);
    assign phase_inc_c = last_c ? '0 : phase + LDD0_0'(1);
    assign cnt_inc_c   = (Ga_period_cnt == 16'hFFFF) ? Ga_period_cnt : Ga_period_cnt + 16'd1;

    always_ff @(posedge Ga_clk200 or posedge Ga_rst) begin
        if (Ga_rst) begin
            state         <= S_IDLE;
            p_reg         <= '0;
            weff_reg      <= '0;
            phase         <= '0;
            Ga_gate       <= 1'b0;
            Ga_busy       <= 1'b0;
            Ga_period_cnt <= '0;
            Ga_wdis       <= TOP0_0'(ST_IDLE);
        end else begin
            state         <= state_nxt;
            p_reg         <= p_nxt;
            weff_reg      <= weff_nxt;
            phase         <= phase_nxt;
            Ga_gate       <= gate_nxt;
            Ga_busy       <= busy_nxt;
            Ga_period_cnt <= cnt_nxt;
            Ga_wdis       <= wdis_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        p_nxt       = p_reg;
        weff_nxt    = weff_reg;
        phase_nxt   = phase;
        gate_nxt    = 1'b0;
        cnt_nxt     = Ga_period_cnt;
        wdis_nxt    = Ga_wdis;
        done_trig_c = 1'b0;

        case (state)
            S_IDLE: begin
                if (Ga_com_open && !Ga_com_close) begin
                    if (Ga_com_plus != '0) begin
                        state_nxt = S_RUN;
                        p_nxt     = Ga_com_plus;
                        weff_nxt  = weff_c;
                        phase_nxt = '0;
                        cnt_nxt   = '0;
                        wdis_nxt  = TOP0_0'(ST_RUN);
                    end else begin
                        wdis_nxt    = TOP0_0'(ST_ERR);
                        done_trig_c = 1'b1;
                    end
                end
            end
            S_RUN, S_STOP: begin
                gate_nxt  = gate_on_c;
                phase_nxt = phase_inc_c;
                if (last_c) begin
                    cnt_nxt = cnt_inc_c;
                end
                // A close on the last phase makes the current period the final one
                if ((state == S_STOP || Ga_com_close) && last_c) begin
                    state_nxt   = S_IDLE;
                    gate_nxt    = 1'b0;
                    phase_nxt   = '0;
                    wdis_nxt    = TOP0_0'(ST_CLOSED);
                    done_trig_c = 1'b1;
                end else if (state == S_RUN && Ga_com_close) begin
                    state_nxt = S_STOP;
                    wdis_nxt  = TOP0_0'(ST_STOP);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    tla_pulse_stretch #(
        .LEN (DONE_STR)
    ) u_done_stretch (
        .clk   (Ga_clk200),
        .rst   (Ga_rst),
        .trig  (done_trig_c),
        .pulse (Ga_done)
    );

endmodule

// File: tb/tb_tla_ga_com_resp.sv
// Bench for tla_ga_com_resp: directed scenarios plus randomized commands,
// checked every cycle against an edge-count arithmetic model.
module tb_tla_ga_com_resp;
    import tla_pkg::*;

    localparam int unsigned DSTR = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        open;
    logic        close;
    logic [2:0]  wd;
    logic [31:0] plus;
    logic        Ga_gate, Ga_busy, Ga_done;
    logic [15:0] Ga_period_cnt;
    logic [2:0]  Ga_wdis;

    always #5 clk = ~clk;

    tla_ga_com_resp #(
        .LDD0_0   (32),
        .TOP0_0   (3),
        .DONE_STR (DSTR)
    ) dut (
        .Ga_clk200     (clk),
        .Ga_rst        (rst),
        .Ga_com_open   (open),
        .Ga_com_close  (close),
        .Ga_com_wdis   (wd),
        .Ga_com_plus   (plus),
        .Ga_gate       (Ga_gate),
        .Ga_busy       (Ga_busy),
        .Ga_period_cnt (Ga_period_cnt),
        .Ga_wdis       (Ga_wdis),
        .Ga_done       (Ga_done)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a session is described by its open edge k0, period P and the
    // edge ef on which it ends; outputs follow from edge arithmetic.
    int         n         = 0;
    int         k0        = 0;
    int         mp        = 1;
    int         mweff     = 0;
    int         ec        = -1;
    int         ef        = -1;
    int         last_trig = -1000;
    bit         act       = 1'b0;
    bit         m_gate    = 1'b0;
    int         m_cnt     = 0;
    logic [2:0] m_st      = ST_IDLE;

    always @(posedge clk) begin : model
        int ph;
        int w;
        n++;
        if (rst) begin
            act = 1'b0; m_gate = 1'b0; m_cnt = 0; m_st = ST_IDLE; last_trig = -1000;
        end else if (!act) begin
            m_gate = 1'b0;
            if (open && !close) begin
                if (plus == 0) begin
                    m_st = ST_ERR;
                    last_trig = n;
                end else begin
                    act   = 1'b1;
                    k0    = n;
                    mp    = int'(plus);
                    w     = 1 << wd;
                    mweff = (w < mp - 1) ? w : mp - 1;
                    ec    = -1;
                    m_cnt = 0;
                    m_st  = ST_RUN;
                end
            end
        end else begin
            ph = (n - k0 - 1) % mp;
            if (ec < 0 && close) begin
                ec = n;
                ef = n + (mp - 1 - ph);
            end
            m_cnt = (n - k0) / mp;
            if (m_cnt > 65535) m_cnt = 65535;
            if (ec >= 0 && n == ef) begin
                act = 1'b0; m_gate = 1'b0; m_st = ST_CLOSED; last_trig = n;
            end else begin
                m_gate = (mp == 1) || (ph < mweff);
                m_st   = (ec >= 0) ? ST_STOP : ST_RUN;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("gate", int'(Ga_gate), int'(m_gate));
            chk("busy", int'(Ga_busy), int'(act));
            chk("period_cnt", int'(Ga_period_cnt), m_cnt);
            chk("wdis", int'(Ga_wdis), int'(m_st));
            chk("done", int'(Ga_done), int'((n - last_trig) < int'(DSTR)));
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse_open(input int p, input int w);
        open = 1'b1; plus = 32'(p); wd = 3'(w);
        step(1);
        open = 1'b0;
    endtask

    task automatic pulse_close();
        close = 1'b1;
        step(1);
        close = 1'b0;
    endtask

    initial begin
        int         c;
        int         first;
        logic [7:0] pat;
        rst = 1'b1; open = 1'b0; close = 1'b0; wd = 3'd0; plus = 32'd0;
        repeat (5) begin
            @(negedge clk);
            open = ~open; close = 1'($urandom_range(0, 1)); plus = 32'd10; wd = 3'd2;
        end
        @(negedge clk);
        open = 1'b0; close = 1'b0;
        cmp_en = 1'b1;
        chk("rst_gate", int'(Ga_gate), 0);
        chk("rst_busy", int'(Ga_busy), 0);
        chk("rst_wdis", int'(Ga_wdis), 0);
        chk("rst_pcnt", int'(Ga_period_cnt), 0);
        chk("rst_done", int'(Ga_done), 0);
        rst = 1'b0;
        step(3);

        // Basic run and graceful close at phase 5 of period 3
        pulse_open(10, 2);
        c = 0; first = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (i == 0) first = int'(Ga_gate);
            c += int'(Ga_gate);
        end
        chk("first_gate", first, 1);
        chk("gate_high_of_10", c, 4);
        chk("run_status", int'(Ga_wdis), 1);
        chk("run_busy", int'(Ga_busy), 1);
        step(15);
        pulse_close();
        chk("stop_status", int'(Ga_wdis), 2);
        step(3);
        chk("stop_pcnt", int'(Ga_period_cnt), 2);
        chk("stop_busy", int'(Ga_busy), 1);
        step(1);
        chk("closed_status", int'(Ga_wdis), 3);
        chk("closed_busy", int'(Ga_busy), 0);
        chk("closed_pcnt", int'(Ga_period_cnt), 3);
        c = int'(Ga_done);
        for (int i = 0; i < 7; i++) begin
            step(1);
            c += int'(Ga_done);
        end
        chk("done_len", c, 4);

        // Zero period is an error
        pulse_open(0, 1);
        chk("err_status", int'(Ga_wdis), 4);
        chk("err_done", int'(Ga_done), 1);
        chk("err_busy", int'(Ga_busy), 0);
        step(6);

        // Period 1 holds the gate high
        pulse_open(1, 0);
        step(1);
        c = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            c += int'(Ga_gate);
        end
        chk("p1_gate_high", c, 8);
        pulse_close();
        chk("p1_closed", int'(Ga_wdis), 3);
        step(6);

        // Width capped at P-1
        pulse_open(4, 3);
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            pat = {pat[6:0], Ga_gate};
        end
        chk("p4_pattern", int'(pat), 8'hEE);
        pulse_close();
        for (int i = 0; i < 10 && Ga_busy; i++) step(1);
        chk("p4_stop_timeout", int'(Ga_busy), 0);
        step(6);

        // Open and close together in IDLE
        open = 1'b1; close = 1'b1; plus = 32'd7; wd = 3'd1;
        step(1);
        open = 1'b0; close = 1'b0;
        chk("idle_both_busy", int'(Ga_busy), 0);
        chk("idle_both_wdis", int'(Ga_wdis), 3);
        step(2);

        // Open during RUN is ignored; open+close together in RUN stops
        pulse_open(10, 0);
        step(3);
        pulse_open(3, 2);
        step(20);
        chk("retrig_pcnt", int'(Ga_period_cnt), 2);
        open = 1'b1; close = 1'b1;
        step(1);
        open = 1'b0; close = 1'b0;
        chk("run_both_stop", int'(Ga_wdis), 2);
        for (int i = 0; i < 15 && Ga_busy; i++) step(1);
        chk("run_both_timeout", int'(Ga_busy), 0);
        step(6);

        // Reset mid-run aborts without done
        pulse_open(6, 1);
        step(4);
        rst = 1'b1;
        #1;
        chk("abort_gate", int'(Ga_gate), 0);
        chk("abort_wdis", int'(Ga_wdis), 0);
        chk("abort_busy", int'(Ga_busy), 0);
        chk("abort_done", int'(Ga_done), 0);
        step(2);
        rst = 1'b0;
        step(6);

        // Randomized commands
        for (int i = 0; i < 2000; i++) begin
            open  = ($urandom_range(0, 19) == 0);
            close = ($urandom_range(0, 24) == 0);
            plus  = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
            wd    = 3'($urandom_range(0, 7));
            rst   = ($urandom_range(0, 299) == 0);
            step(1);
        end
        open = 1'b0; close = 1'b0; rst = 1'b0;
        step(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tla_ga_com_resp.md
Name: tla_ga_com_resp

Overview:
- Ga_clk200-domain responder for the open/close command pulses that arrive from the Gc_clk125 domain.
- On an open pulse it latches the command period and width and runs a periodic gate train. On a close pulse it finishes the current period and stops.
- It returns a held 3-bit status and a stretched done pulse, sized so that the slower 125 MHz side can sample them safely.

Parameters:
- LDD0_0, 32, width of the Ga_com_plus period field in Ga_clk200 cycles.
- TOP0_0, 3, width of the Ga_com_wdis width code and of the Ga_wdis status bus.
- DONE_STR, 4, length of the Ga_done pulse in Ga_clk200 cycles. Must be ≥2; 4 gives 20 ns.

Ports:
- Ga_clk200  in  1  200 MHz clock; the only clock of the block.
- Ga_rst  in  1  asynchronous reset, active-high.
- Ga_com_open  in  1  single-cycle open command (already synchronised into this domain).
- Ga_com_close  in  1  single-cycle close command (already synchronised).
- Ga_com_wdis  in  TOP0_0  gate width code. Gate width is 2^code cycles.
- Ga_com_plus  in  LDD0_0  gate period in cycles. 0 is illegal.
- Ga_gate  out  1  periodic gate output.
- Ga_busy  out  1  high in RUN and STOP.
- Ga_period_cnt  out  16  number of completed periods; saturates at 16'hFFFF.
- Ga_wdis  out  TOP0_0  held status code, returned to the Gc domain.
- Ga_done  out  1  high for exactly DONE_STR cycles when the block returns to IDLE.

Behaviour:
- Reset (asynchronous assert):
  - State goes to IDLE.
  - Ga_gate=0, Ga_busy=0, Ga_done=0, Ga_period_cnt=0, Ga_wdis=3'b000.
  - Latched period, width and internal counters clear.
  - Reset asserted mid-RUN aborts immediately. No done pulse is generated.
- Status codes:
  - 000 idle (never run)
  - 001 running
  - 010 stopping
  - 011 closed normally
  - 100 error (zero period)
  - Ga_wdis changes only on a state transition, so it is quasi-static for the Gc side.
- IDLE:
  - Open alone with Ga_com_plus≠0:
    - Latch plus into P_reg and compute width W=1<<wdis.
    - Clear the phase counter and Ga_period_cnt.
    - Go to RUN, status 001.
  - Open alone with Ga_com_plus==0: stay in IDLE, status 100, pulse Ga_done.
  - Close alone: ignored.
  - Open and close in the same cycle: both ignored, status unchanged.
- RUN:
  - The phase counter counts 0..P_reg-1 and wraps.
  - Ga_gate is registered, so it is high during phase values 0..Weff-1, delayed one cycle. Weff = min(W, P_reg-1).
  - Exception: when P_reg==1, Ga_gate is held constantly high.
  - First Ga_gate=1 appears 1 cycle after the open pulse.
  - On each wrap, Ga_period_cnt increments with saturation.
  - Open: ignored (no retrigger, latched values unchanged).
  - Close, including a close coincident with an open: go to STOP, status 010.
- STOP:
  - Gate generation continues until the phase counter reaches P_reg-1.
  - On that cycle: the final period is counted, state goes to IDLE, status 011, Ga_done asserts, Ga_busy deasserts.
  - Open and close are ignored in STOP.
  - If close arrives on the last phase of RUN, that period is the final one.
- Ga_done: a DONE_STR-cycle pulse from a down-counter. A new trigger while the pulse is active reloads the counter.
- Arithmetic:
  - The phase counter is LDD0_0 bits; the comparison is against P_reg-1.
  - The width shift has TOP0_0 bits of code, so W is at most 128.
  - Ga_gate never glitches: it is a registered output.

Decomposition:
- Shared package tla_pkg holds:
  - status code localparams: ST_IDLE, ST_RUN, ST_STOP, ST_CLOSED, ST_ERR
  - the FSM state encoding
  - the DONE_STR default
- One sub-module, tla_pulse_stretch (down-counter stretcher), produces Ga_done. It is reusable for other slow-domain handoffs.

Test Plan:
- Reset then idle: Ga_rst held 5 cycles → all outputs 0, Ga_wdis=000; inputs toggled under reset have no effect.
- Basic run: open with plus=10, wdis=2 →
  - Ga_gate high 4 cycles, low 6, repeating; first high 1 cycle after open.
  - Ga_wdis=001, Ga_busy=1.
  - After 3 periods, Ga_period_cnt=3.
- Graceful close: close at phase 5 of period 3 (plus=10) →
  - Gate completes period 3.
  - Ga_wdis goes 010, then 011 at phase 9.
  - Ga_done high exactly 4 cycles; Ga_period_cnt=3.
- Boundaries:
  - plus=0 → status 100, done pulse, no gate.
  - plus=1 → gate constantly high.
  - plus=4, wdis=3 → Weff=3: gate high 3 cycles, low 1.
- Simultaneous events:
  - Open and close together in IDLE → no change.
  - Open during RUN → no retrigger; period unchanged.
  - Open and close together in RUN → STOP.
- Reset mid-run: assert Ga_rst in RUN → immediate IDLE, gate 0, status 000, no Ga_done.
